// File: rtl/uart_crypt_session_ctrl_if.sv
// Bus bundle between the UART session controller and its neighbours.
//   rx_data/rx_valid       : bytes from uart_receiver
//   crypt_in/crypt_start   : packed frame and start pulse to the crypt core
//   crypt_done/crypt_out   : completion pulse and result from the crypt core
//   tx_data/tx_start       : bytes to uart_transmitter
//   tx_done                : transmitter finished a byte
//   busy/frame_done/err_timeout/rx_overrun : session status
// master: the controller side; slave: the surrounding UART/crypt environment.
interface uart_crypt_session_ctrl_if #(
  parameter int unsigned DBITS    = 8,
  parameter int unsigned RX_BYTES = 32,
  parameter int unsigned TX_BYTES = 16
) ();
  logic [DBITS-1:0]          rx_data;
  logic                      rx_valid;
  logic [DBITS*RX_BYTES-1:0] crypt_in;
  logic                      crypt_start;
  logic                      crypt_done;
  logic [DBITS*TX_BYTES-1:0] crypt_out;
  logic [DBITS-1:0]          tx_data;
  logic                      tx_start;
  logic                      tx_done;
  logic                      busy;
  logic                      frame_done;
  logic                      err_timeout;
  logic                      rx_overrun;

  modport master (
    input  rx_data, rx_valid, crypt_done, crypt_out, tx_done,
    output crypt_in, crypt_start, tx_data, tx_start,
           busy, frame_done, err_timeout, rx_overrun
  );

  modport slave (
    output rx_data, rx_valid, crypt_done, crypt_out, tx_done,
    input  crypt_in, crypt_start, tx_data, tx_start,
           busy, frame_done, err_timeout, rx_overrun
  );
endinterface

// File: rtl/uart_crypt_session_ctrl.sv
// Sequences one crypto session: packs RX_BYTES UART bytes (first byte = MSB)
// into crypt_in, pulses crypt_start, waits for crypt_done, then streams the
// TX_BYTES result MSB-first to the UART transmitter with a tx_start/tx_done
// handshake. Aborts with err_timeout on RX silence or a stalled crypt core;
// bytes arriving while the frame is in flight are dropped with rx_overrun.
// Ports:
//   clk_100MHz : system clock
//   reset      : asynchronous active-high reset
//   bus        : uart_crypt_session_ctrl_if.master (all outputs registered)
module uart_crypt_session_ctrl #(
  parameter int unsigned DBITS         = 8,
  parameter int unsigned RX_BYTES      = 32,
  parameter int unsigned TX_BYTES      = 16,
  parameter int unsigned RX_IDLE_LIMIT = 1000000,
  parameter int unsigned CRYPT_TIMEOUT = 4096
) (
  input  logic                       clk_100MHz,
  input  logic                       reset,
  uart_crypt_session_ctrl_if.master  bus
);

  localparam int unsigned IN_W   = DBITS * RX_BYTES;
  localparam int unsigned OUT_W  = DBITS * TX_BYTES;
  localparam int unsigned RXC_W  = $clog2(RX_BYTES + 1);
  localparam int unsigned IDLE_W = $clog2(RX_IDLE_LIMIT + 1);
  localparam int unsigned WAIT_W = $clog2(CRYPT_TIMEOUT + 1);
  localparam int unsigned TXI_W  = $clog2(TX_BYTES + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RECV   = 3'd1,
    CRYPT  = 3'd2,
    WAIT   = 3'd3,
    SEND   = 3'd4,
    TXWAIT = 3'd5
  } state_t;

  state_t            state;
  logic [RXC_W-1:0]  rx_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [TXI_W-1:0]  tx_idx;
  logic [OUT_W-1:0]  tx_shift;

  // Session FSM; pulse outputs default low each cycle.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      rx_cnt          <= '0;
      idle_cnt        <= '0;
      wait_cnt        <= '0;
      tx_idx          <= '0;
      tx_shift        <= '0;
      bus.crypt_in    <= '0;
      bus.crypt_start <= 1'b0;
      bus.tx_data     <= '0;
      bus.tx_start    <= 1'b0;
      bus.busy        <= 1'b0;
      bus.frame_done  <= 1'b0;
      bus.err_timeout <= 1'b0;
      bus.rx_overrun  <= 1'b0;
    end else begin
      bus.crypt_start <= 1'b0;
      bus.tx_start    <= 1'b0;
      bus.frame_done  <= 1'b0;
      bus.err_timeout <= 1'b0;
      bus.rx_overrun  <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.rx_valid) begin
            bus.crypt_in[IN_W-1 -: DBITS] <= bus.rx_data;
            rx_cnt   <= RXC_W'(1);
            idle_cnt <= '0;
            bus.busy <= 1'b1;
            state    <= RECV;
          end
        end

        RECV: begin
          // A byte on the timeout cycle takes priority over the abort.
          if (bus.rx_valid) begin
            for (int unsigned k = 1; k < RX_BYTES; k++) begin
              if (rx_cnt == RXC_W'(k)) begin
                bus.crypt_in[DBITS*(RX_BYTES-k)-1 -: DBITS] <= bus.rx_data;
              end
            end
            idle_cnt <= '0;
            if (rx_cnt == RXC_W'(RX_BYTES - 1)) begin
              rx_cnt          <= '0;
              bus.crypt_start <= 1'b1;
              state           <= CRYPT;
            end else begin
              rx_cnt <= rx_cnt + RXC_W'(1);
            end
          end else if (idle_cnt == IDLE_W'(RX_IDLE_LIMIT - 1)) begin
            bus.err_timeout <= 1'b1;
            rx_cnt          <= '0;
            idle_cnt        <= '0;
            bus.busy        <= 1'b0;
            state           <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
          end
        end

        CRYPT: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end

        WAIT: begin
          if (bus.crypt_done) begin
            tx_shift <= bus.crypt_out;
            tx_idx   <= '0;
            state    <= SEND;
          end else if (wait_cnt == WAIT_W'(CRYPT_TIMEOUT - 1)) begin
            bus.err_timeout <= 1'b1;
            bus.busy        <= 1'b0;
            state           <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        SEND: begin
          bus.tx_start <= 1'b1;
          bus.tx_data  <= tx_shift[OUT_W-1 -: DBITS];
          state        <= TXWAIT;
        end

        TXWAIT: begin
          if (bus.tx_done) begin
            if (tx_idx == TXI_W'(TX_BYTES - 1)) begin
              bus.frame_done <= 1'b1;
              bus.busy       <= 1'b0;
              state          <= IDLE;
            end else begin
              tx_idx   <= tx_idx + TXI_W'(1);
              tx_shift <= tx_shift << DBITS;
              state    <= SEND;
            end
          end
        end

        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase

      // Bytes are only accepted while assembling a frame.
      if (bus.rx_valid && (state inside {CRYPT, WAIT, SEND, TXWAIT})) begin
        bus.rx_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_crypt_session_ctrl.sv
// Self-checking bench for uart_crypt_session_ctrl: expected crypt_in frames
// and TX bytes are queued when stimulus is driven and compared by a monitor
// when crypt_start / tx_start fire. Inputs are driven and outputs sampled on
// the falling clock edge.
module tb_uart_crypt_session_ctrl;

  localparam int unsigned DBITS         = 8;
  localparam int unsigned RX_BYTES      = 32;
  localparam int unsigned TX_BYTES      = 16;
  localparam int unsigned RX_IDLE_LIMIT = 200;
  localparam int unsigned CRYPT_TIMEOUT = 64;
  localparam int unsigned TX_GAP        = 20;
  localparam int unsigned IN_W          = DBITS * RX_BYTES;
  localparam int unsigned OUT_W         = DBITS * TX_BYTES;

  logic clk;
  logic rst;

  uart_crypt_session_ctrl_if #(
    .DBITS(DBITS), .RX_BYTES(RX_BYTES), .TX_BYTES(TX_BYTES)
  ) bus ();

  uart_crypt_session_ctrl #(
    .DBITS(DBITS), .RX_BYTES(RX_BYTES), .TX_BYTES(TX_BYTES),
    .RX_IDLE_LIMIT(RX_IDLE_LIMIT), .CRYPT_TIMEOUT(CRYPT_TIMEOUT)
  ) dut (
    .clk_100MHz(clk),
    .reset(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int last_drv = 0;
  int n_tx = 0;
  int n_start = 0;
  int n_frame = 0;
  int n_err = 0;
  int n_ovr = 0;
  logic [IN_W-1:0]  exp_crypt_q[$];
  logic [DBITS-1:0] exp_tx_q[$];
  logic [IN_W-1:0]  cur_frame;

  task automatic check(input string tag, input logic [IN_W-1:0] got, input logic [IN_W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.crypt_start) begin
        n_start++;
        check("crypt_q_nonempty", IN_W'(exp_crypt_q.size() != 0), IN_W'(1));
        if (exp_crypt_q.size() != 0) check("crypt_in", bus.crypt_in, exp_crypt_q.pop_front());
      end
      if (bus.tx_start) begin
        n_tx++;
        check("tx_q_nonempty", IN_W'(exp_tx_q.size() != 0), IN_W'(1));
        if (exp_tx_q.size() != 0) check("tx_data", IN_W'(bus.tx_data), IN_W'(exp_tx_q.pop_front()));
      end
      if (bus.frame_done)  n_frame++;
      if (bus.err_timeout) n_err++;
      if (bus.rx_overrun)  n_ovr++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [DBITS-1:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    last_drv     = cyc;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  // Sends a full frame of base, base+1, ...; returns on the crypt_start sample.
  task automatic send_frame(input logic [DBITS-1:0] base);
    logic [IN_W-1:0] w;
    w = '0;
    for (int k = 0; k < int'(RX_BYTES); k++) w[DBITS*(int'(RX_BYTES)-k)-1 -: DBITS] = DBITS'(int'(base) + k);
    exp_crypt_q.push_back(w);
    cur_frame = w;
    for (int k = 0; k < int'(RX_BYTES); k++) send_byte(DBITS'(int'(base) + k));
    check("start_lat", IN_W'(bus.crypt_start), IN_W'(1));
    check("busy_frame", IN_W'(bus.busy), IN_W'(1));
  endtask

  function automatic logic [OUT_W-1:0] rand_res();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic do_crypt(input logic [OUT_W-1:0] res, input int delay);
    tick(delay);
    bus.crypt_out  = res;
    bus.crypt_done = 1'b1;
    for (int j = 0; j < int'(TX_BYTES); j++) exp_tx_q.push_back(res[DBITS*(int'(TX_BYTES)-j)-1 -: DBITS]);
    @(negedge clk);
    bus.crypt_done = 1'b0;
    bus.crypt_out  = rand_res();
    check("tx_first_early", IN_W'(bus.tx_start), IN_W'(0));
    @(negedge clk);
    check("tx_first_lat", IN_W'(bus.tx_start), IN_W'(1));
  endtask

  // Transmitter model: tx_done TX_GAP cycles after each tx_start.
  task automatic tx_respond(input int n, input int ovr_at, input int rst_at);
    for (int i = 0; i < n; i++) begin
      int k;
      k = 0;
      while (bus.tx_start !== 1'b1 && k < 200) begin
        @(negedge clk);
        k++;
      end
      if (bus.tx_start !== 1'b1) begin
        check("tx_start_wait", IN_W'(bus.tx_start), IN_W'(1));
        return;
      end
      if (i == ovr_at) begin
        tick(5);
        bus.rx_data  = 8'h55;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        check("rx_overrun", IN_W'(bus.rx_overrun), IN_W'(1));
        check("crypt_in_hold", bus.crypt_in, cur_frame);
        tick(int'(TX_GAP) - 6);
      end else begin
        tick(int'(TX_GAP));
      end
      bus.tx_done = 1'b1;
      @(negedge clk);
      bus.tx_done = 1'b0;
      if (i == rst_at) begin
        check("pre_rst_busy", IN_W'(bus.busy), IN_W'(1));
        rst = 1'b1;
        #1;
        check("rst_mid_ctl", IN_W'({bus.busy, bus.crypt_start, bus.tx_start,
                                    bus.frame_done, bus.err_timeout, bus.rx_overrun}), IN_W'(0));
        check("rst_mid_crypt_in", bus.crypt_in, IN_W'(0));
        check("rst_mid_tx_data", IN_W'(bus.tx_data), IN_W'(0));
        return;
      end else if (i == n - 1) begin
        check("frame_done", IN_W'(bus.frame_done), IN_W'(1));
        check("busy_end", IN_W'(bus.busy), IN_W'(0));
      end else begin
        check("tx_next_early", IN_W'(bus.tx_start), IN_W'(0));
        @(negedge clk);
        check("tx_next_lat", IN_W'(bus.tx_start), IN_W'(1));
      end
    end
  endtask

  task automatic wait_err(input int limit, output int at);
    int k;
    k = 0;
    while (bus.err_timeout !== 1'b1 && k < limit) begin
      @(negedge clk);
      k++;
    end
    at = cyc;
    check("err_seen", IN_W'(bus.err_timeout), IN_W'(1));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, b, at, tx0, st0;
    logic [IN_W-1:0] lit;
    bus.rx_data    = '0;
    bus.rx_valid   = 1'b0;
    bus.crypt_done = 1'b0;
    bus.crypt_out  = '0;
    bus.tx_done    = 1'b0;
    rst            = 1'b1;
    tick(3);
    check("rst_ctl", IN_W'({bus.busy, bus.crypt_start, bus.tx_start,
                            bus.frame_done, bus.err_timeout, bus.rx_overrun}), IN_W'(0));
    check("rst_crypt_in", bus.crypt_in, IN_W'(0));
    check("rst_tx_data", IN_W'(bus.tx_data), IN_W'(0));
    rst = 1'b0;
    tick(2);

    // Bytes 00..1F, then result A0..AF.
    send_frame(8'h00);
    lit = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    check("t1_crypt_in_lit", bus.crypt_in, lit);
    do_crypt(128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf, 3);
    tx_respond(int'(TX_BYTES), -1, -1);
    tick(1);
    check("t2_busy_idle", IN_W'(bus.busy), IN_W'(0));
    check("t2_tx_count", IN_W'(n_tx), IN_W'(TX_BYTES));
    check("t2_frame_count", IN_W'(n_frame), IN_W'(1));

    // Partial frame; a byte on the timeout cycle wins, then silence aborts.
    tick(2);
    for (int k = 0; k < 4; k++) send_byte(DBITS'(8'hC0 + k));
    b = last_drv;
    tick(int'(RX_IDLE_LIMIT) - 1);
    check("t3_coincident_cyc", IN_W'(cyc), IN_W'(b + int'(RX_IDLE_LIMIT)));
    send_byte(8'hC4);
    check("t3_no_timeout", IN_W'(bus.err_timeout), IN_W'(0));
    check("t3_still_busy", IN_W'(bus.busy), IN_W'(1));
    b = last_drv;
    wait_err(int'(RX_IDLE_LIMIT) + 20, at);
    check("t3_to_lat", IN_W'(at), IN_W'(b + int'(RX_IDLE_LIMIT) + 1));
    check("t3_busy", IN_W'(bus.busy), IN_W'(0));
    tick(3);
    check("t3_err_count", IN_W'(n_err), IN_W'(1));
    send_frame(8'h40);
    do_crypt(rand_res(), 10);
    tx_respond(int'(TX_BYTES), -1, -1);

    // Crypt core never answers.
    tick(2);
    tx0 = n_tx;
    send_frame(8'h80);
    s = cyc;
    wait_err(int'(CRYPT_TIMEOUT) + 20, at);
    check("t4_to_lat", IN_W'(at), IN_W'(s + int'(CRYPT_TIMEOUT) + 1));
    check("t4_busy", IN_W'(bus.busy), IN_W'(0));
    tick(3);
    check("t4_no_tx", IN_W'(n_tx), IN_W'(tx0));
    check("t4_err_count", IN_W'(n_err), IN_W'(2));

    // Overrun during TXWAIT, then stray handshakes in IDLE.
    send_frame(8'h20);
    do_crypt(rand_res(), 2);
    tx_respond(int'(TX_BYTES), 6, -1);
    check("t5_ovr_count", IN_W'(n_ovr), IN_W'(1));
    tick(2);
    tx0 = n_tx;
    st0 = n_start;
    bus.crypt_done = 1'b1;
    bus.tx_done    = 1'b1;
    @(negedge clk);
    bus.crypt_done = 1'b0;
    bus.tx_done    = 1'b0;
    tick(3);
    check("t5_stray_busy", IN_W'(bus.busy), IN_W'(0));
    check("t5_stray_tx", IN_W'(n_tx), IN_W'(tx0));
    check("t5_stray_start", IN_W'(n_start), IN_W'(st0));
    check("t5_crypt_in_kept", bus.crypt_in, cur_frame);

    // Reset in SEND after byte 7, then a fresh frame.
    send_frame(8'hE0);
    do_crypt(rand_res(), 1);
    tx_respond(int'(TX_BYTES), -1, 7);
    exp_tx_q.delete();
    tick(2);
    rst = 1'b0;
    tick(3);
    check("t6_post_rst", IN_W'({bus.busy, bus.tx_start, bus.frame_done}), IN_W'(0));
    send_frame(8'h60);
    do_crypt(rand_res(), 4);
    tx_respond(int'(TX_BYTES), -1, -1);

    tick(3);
    check("end_crypt_q", IN_W'(exp_crypt_q.size()), IN_W'(0));
    check("end_tx_q", IN_W'(exp_tx_q.size()), IN_W'(0));
    check("end_frames", IN_W'(n_frame), IN_W'(4));
    check("end_errs", IN_W'(n_err), IN_W'(2));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
